apb_dual_master_arb: RTL and testbench

- Two-master to one-slave APB3 arbiter that shares the fabric APB slave segment (CoreAPB3 to CoreGPIO path).
- Master 0 is the MSS FIC_0 APB master; master 1 is a fabric sequencer.
- Round-robin arbitration at transfer granularity. Each granted transfer is re-issued to the slave as a clean SETUP/ACCESS pair with registered outputs.
- A wait-state timeout guards against a slave that never asserts PREADY.

---
 rtl/apb_arb_pkg.sv | 24 ++
 rtl/apb_rr_pick2.sv | 21 ++
 rtl/apb_dual_master_arb.sv | 146 ++++++++++++++
 tb/tb_apb_dual_master_arb.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types for the two-master APB3 arbiter: FSM states, grant codes,
// and the width helper for the wait-state timeout counter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // ceil(log2(n)), never less than 1 so a disabled timeout still has a counter
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/apb_rr_pick2.sv
// Two-way round-robin picker: the requester not granted last wins a tie.
// Purely combinational, one-hot grant output.
module apb_rr_pick2
    import apb_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = GNT_NONE;
        unique case (i_req)
            2'b01:   o_grant = GNT_M0;
            2'b10:   o_grant = GNT_M1;
            2'b11:   o_grant = i_last ? GNT_M0 : GNT_M1;
            default: o_grant = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/apb_dual_master_arb.sv
// Two-master to one-slave APB3 arbiter, round-robin per transfer, with each
// granted transfer re-issued as a registered SETUP/ACCESS pair and a wait timeout.
module apb_dual_master_arb
    import apb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  M0_PSEL,
    input  logic                  M0_PENABLE,
    input  logic                  M0_PWRITE,
    input  logic [ADDR_WIDTH-1:0] M0_PADDR,
    input  logic [DATA_WIDTH-1:0] M0_PWDATA,
    output logic [DATA_WIDTH-1:0] M0_PRDATA,
    output logic                  M0_PREADY,
    output logic                  M0_PSLVERR,
    input  logic                  M1_PSEL,
    input  logic                  M1_PENABLE,
    input  logic                  M1_PWRITE,
    input  logic [ADDR_WIDTH-1:0] M1_PADDR,
    input  logic [DATA_WIDTH-1:0] M1_PWDATA,
    output logic [DATA_WIDTH-1:0] M1_PRDATA,
    output logic                  M1_PREADY,
    output logic                  M1_PSLVERR,
    output logic                  S_PSEL,
    output logic                  S_PENABLE,
    output logic                  S_PWRITE,
    output logic [ADDR_WIDTH-1:0] S_PADDR,
    output logic [DATA_WIDTH-1:0] S_PWDATA,
    input  logic [DATA_WIDTH-1:0] S_PRDATA,
    input  logic                  S_PREADY,
    input  logic                  S_PSLVERR,
    output logic [1:0]            GRANT,
    output logic                  TIMEOUT_ERR
);

    localparam int CNT_W = clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_gnt;
    logic                  r_last;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_slverr;
    logic                  r_to_err;
    logic [CNT_W-1:0]      r_cnt;
    logic [1:0]            w_pick;
    logic                  w_timeout;
    logic                  w_resp;
    logic                  w_unused;

    // PENABLE is not needed: PSEL alone marks a pending request
    assign w_unused  = &{1'b0, M0_PENABLE, M1_PENABLE};
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);

    apb_rr_pick2 u_pick (
        .i_req   ({M1_PSEL, M0_PSEL}),
        .i_last  (r_last),
        .o_grant (w_pick)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_pick != GNT_NONE) w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: if (S_PREADY || w_timeout) w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        S_PSEL     = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
        S_PENABLE  = (r_state == ST_ACCESS);
        S_PWRITE   = r_write;
        S_PADDR    = r_addr;
        S_PWDATA   = r_wdata;
        GRANT      = r_gnt;
        TIMEOUT_ERR = r_to_err;
        w_resp     = (r_state == ST_RESP);
        M0_PREADY  = w_resp && r_gnt[0];
        M1_PREADY  = w_resp && r_gnt[1];
        M0_PSLVERR = M0_PREADY && r_slverr;
        M1_PSLVERR = M1_PREADY && r_slverr;
        M0_PRDATA  = M0_PREADY ? r_rdata : '0;
        M1_PRDATA  = M1_PREADY ? r_rdata : '0;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_gnt    <= GNT_NONE;
            r_last   <= 1'b1;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_write  <= 1'b0;
            r_rdata  <= '0;
            r_slverr <= 1'b0;
            r_to_err <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_to_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pick != GNT_NONE) begin
                        r_gnt   <= w_pick;
                        r_addr  <= w_pick[1] ? M1_PADDR  : M0_PADDR;
                        r_wdata <= w_pick[1] ? M1_PWDATA : M0_PWDATA;
                        r_write <= w_pick[1] ? M1_PWRITE : M0_PWRITE;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                    if (S_PREADY) begin
                        r_rdata  <= S_PRDATA;
                        r_slverr <= S_PSLVERR;
                    end else if (w_timeout) begin
                        r_rdata  <= '0;
                        r_slverr <= 1'b1;
                        r_to_err <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_last <= r_gnt[1];
                    r_gnt  <= GNT_NONE;
                    r_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_dual_master_arb.sv
// Directed bench for apb_dual_master_arb: table of single transfers plus
// hand-written arbitration, timeout and mid-transfer reset sequences.
module tb_apb_dual_master_arb;

    logic        PCLK;
    logic        PRESET;
    logic        M0_PSEL, M0_PENABLE, M0_PWRITE;
    logic [31:0] M0_PADDR, M0_PWDATA, M0_PRDATA;
    logic        M0_PREADY, M0_PSLVERR;
    logic        M1_PSEL, M1_PENABLE, M1_PWRITE;
    logic [31:0] M1_PADDR, M1_PWDATA, M1_PRDATA;
    logic        M1_PREADY, M1_PSLVERR;
    logic        S_PSEL, S_PENABLE, S_PWRITE;
    logic [31:0] S_PADDR, S_PWDATA, S_PRDATA;
    logic        S_PREADY, S_PSLVERR;
    logic [1:0]  GRANT;
    logic        TIMEOUT_ERR;

    apb_dual_master_arb #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (4)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .M0_PSEL     (M0_PSEL),
        .M0_PENABLE  (M0_PENABLE),
        .M0_PWRITE   (M0_PWRITE),
        .M0_PADDR    (M0_PADDR),
        .M0_PWDATA   (M0_PWDATA),
        .M0_PRDATA   (M0_PRDATA),
        .M0_PREADY   (M0_PREADY),
        .M0_PSLVERR  (M0_PSLVERR),
        .M1_PSEL     (M1_PSEL),
        .M1_PENABLE  (M1_PENABLE),
        .M1_PWRITE   (M1_PWRITE),
        .M1_PADDR    (M1_PADDR),
        .M1_PWDATA   (M1_PWDATA),
        .M1_PRDATA   (M1_PRDATA),
        .M1_PREADY   (M1_PREADY),
        .M1_PSLVERR  (M1_PSLVERR),
        .S_PSEL      (S_PSEL),
        .S_PENABLE   (S_PENABLE),
        .S_PWRITE    (S_PWRITE),
        .S_PADDR     (S_PADDR),
        .S_PWDATA    (S_PWDATA),
        .S_PRDATA    (S_PRDATA),
        .S_PREADY    (S_PREADY),
        .S_PSLVERR   (S_PSLVERR),
        .GRANT       (GRANT),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        int          m;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] srd;
        logic        serr;
        logic [31:0] erd;
        logic        eerr;
        int          elat;
    } vec_t;

    typedef struct {
        int          waits;
        logic [31:0] rd;
        logic        err;
    } rsp_t;

    int   n_chk = 0;
    int   n_err = 0;
    rsp_t sq[$];
    int   sacc = 0;

    int          setup_n, acc_n, to_n;
    int          rdy_n [2];
    logic        was_acc = 1'b0;
    logic [31:0] sv_addr, sv_wdata;
    logic        sv_wr;
    logic [1:0]  sv_gnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave model: serves the front response after its wait count, drives junk while waiting
    always @(negedge PCLK) begin
        if (S_PSEL && S_PENABLE && sq.size() > 0) begin
            if (sacc == sq[0].waits) begin
                S_PREADY  = 1'b1;
                S_PRDATA  = sq[0].rd;
                S_PSLVERR = sq[0].err;
                void'(sq.pop_front());
            end else begin
                S_PREADY  = 1'b0;
                S_PRDATA  = 32'hBAD0_0BAD;
                S_PSLVERR = 1'b0;
            end
            sacc++;
        end else begin
            S_PREADY  = 1'b0;
            S_PRDATA  = 32'h0;
            S_PSLVERR = 1'b0;
            sacc      = 0;
        end
    end

    always @(negedge PCLK) begin
        if (S_PSEL && !S_PENABLE) setup_n++;
        if (S_PSEL && S_PENABLE) begin
            if (!was_acc) begin
                sv_addr  = S_PADDR;
                sv_wdata = S_PWDATA;
                sv_wr    = S_PWRITE;
                sv_gnt   = GRANT;
            end
            was_acc = 1'b1;
            acc_n++;
        end else begin
            was_acc = 1'b0;
        end
        if (M0_PREADY) rdy_n[0]++;
        if (M1_PREADY) rdy_n[1]++;
        if (TIMEOUT_ERR) to_n++;
    end

    task automatic clr_mon();
        setup_n  = 0;
        acc_n    = 0;
        to_n     = 0;
        rdy_n[0] = 0;
        rdy_n[1] = 0;
    endtask

    task automatic drive(input int m, input logic sel, input logic en,
                         input logic wr, input logic [31:0] a,
                         input logic [31:0] d);
        if (m == 0) begin
            M0_PSEL = sel; M0_PENABLE = en; M0_PWRITE = wr;
            M0_PADDR = a;  M0_PWDATA = d;
        end else begin
            M1_PSEL = sel; M1_PENABLE = en; M1_PWRITE = wr;
            M1_PADDR = a;  M1_PWDATA = d;
        end
    endtask

    // APB master: latency counts cycles after the sampling edge until PREADY is seen
    task automatic master(input int m, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd,
                          output logic er, output int lat);
        logic rdy;
        lat = -1;
        rd  = 32'hX;
        er  = 1'bX;
        @(negedge PCLK);
        drive(m, 1'b1, 1'b0, wr, a, d);
        for (int k = 1; k <= 40; k++) begin
            @(negedge PCLK);
            drive(m, 1'b1, 1'b1, wr, a, d);
            rdy = (m == 0) ? M0_PREADY : M1_PREADY;
            if (rdy) begin
                rd  = (m == 0) ? M0_PRDATA : M1_PRDATA;
                er  = (m == 0) ? M0_PSLVERR : M1_PSLVERR;
                lat = k;
                break;
            end
        end
        drive(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic both_req(input string tag, input logic [31:0] r0,
                            input logic [31:0] r1);
        logic [31:0] rd0, rd1;
        logic        er0, er1;
        int          lat0, lat1;
        sq.push_back('{0, r0, 1'b0});
        sq.push_back('{0, r1, 1'b0});
        fork
            master(0, 1'b0, 32'h10, 32'h0, rd0, er0, lat0);
            master(1, 1'b0, 32'h20, 32'h0, rd1, er1, lat1);
        join
        @(negedge PCLK);
        chk({tag, " m0 lat"}, lat0, 3);
        chk({tag, " m0 rdata"}, rd0, r0);
        chk({tag, " m1 lat"}, lat1, 7);
        chk({tag, " m1 rdata"}, rd1, r1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tv [5];
        logic [31:0] rd;
        logic        er;
        int          lat;

        tv[0] = '{0, 1'b1, 32'h0000_00A0, 32'h0000_0003, 0,
                  32'h0, 1'b0, 32'h0, 1'b0, 3};
        tv[1] = '{1, 1'b0, 32'h0000_0104, 32'h0, 0,
                  32'h5A5A_0001, 1'b0, 32'h5A5A_0001, 1'b0, 3};
        tv[2] = '{1, 1'b0, 32'h0000_0200, 32'h0, 3,
                  32'h0000_0022, 1'b1, 32'h0000_0022, 1'b1, 6};
        tv[3] = '{0, 1'b0, 32'h0000_0300, 32'h0, 2,
                  32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 5};
        tv[4] = '{1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1,
                  32'h0, 1'b1, 32'h0, 1'b1, 4};

        PRESET = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        S_PREADY = 1'b0; S_PRDATA = 32'h0; S_PSLVERR = 1'b0;
        clr_mon();
        repeat (2) @(negedge PCLK);
        chk("reset S_PSEL/PENABLE", {S_PSEL, S_PENABLE}, 2'b00);
        chk("reset GRANT", GRANT, 2'b00);
        chk("reset PREADY", {M0_PREADY, M1_PREADY}, 2'b00);
        chk("reset PSLVERR", {M0_PSLVERR, M1_PSLVERR}, 2'b00);
        chk("reset PRDATA", M0_PRDATA | M1_PRDATA, 32'h0);
        chk("reset TIMEOUT_ERR", TIMEOUT_ERR, 1'b0);
        PRESET = 1'b0;
        @(negedge PCLK);

        for (int i = 0; i < 5; i++) begin
            clr_mon();
            sq.push_back('{tv[i].waits, tv[i].srd, tv[i].serr});
            master(tv[i].m, tv[i].wr, tv[i].addr, tv[i].wdata, rd, er, lat);
            @(negedge PCLK);
            chk($sformatf("v%0d latency", i), lat, tv[i].elat);
            chk($sformatf("v%0d prdata", i), rd, tv[i].erd);
            chk($sformatf("v%0d pslverr", i), er, tv[i].eerr);
            chk($sformatf("v%0d setup cycles", i), setup_n, 1);
            chk($sformatf("v%0d access cycles", i), acc_n, tv[i].waits + 1);
            chk($sformatf("v%0d own pready", i), rdy_n[tv[i].m], 1);
            chk($sformatf("v%0d other pready", i), rdy_n[1 - tv[i].m], 0);
            chk($sformatf("v%0d S_PADDR", i), sv_addr, tv[i].addr);
            chk($sformatf("v%0d S_PWDATA", i), sv_wdata, tv[i].wdata);
            chk($sformatf("v%0d S_PWRITE", i), sv_wr, tv[i].wr);
            chk($sformatf("v%0d GRANT", i), sv_gnt,
                (tv[i].m == 0) ? 2'b01 : 2'b10);
            chk($sformatf("v%0d timeout_err", i), to_n, 0);
        end

        both_req("rr1", 32'h0000_0011, 32'h0000_0022);
        both_req("rr2", 32'h0000_0055, 32'h0000_0066);

        clr_mon();
        sq.push_back('{1000, 32'h0, 1'b0});
        master(0, 1'b0, 32'h40, 32'h0, rd, er, lat);
        @(negedge PCLK);
        sq.delete();
        chk("tmo latency", lat, 6);
        chk("tmo prdata", rd, 32'h0);
        chk("tmo pslverr", er, 1'b1);
        chk("tmo access cycles", acc_n, 4);
        chk("tmo err pulses", to_n, 1);
        clr_mon();
        sq.push_back('{0, 32'h0000_0077, 1'b0});
        master(1, 1'b0, 32'h44, 32'h0, rd, er, lat);
        @(negedge PCLK);
        chk("post-tmo latency", lat, 3);
        chk("post-tmo prdata", rd, 32'h0000_0077);
        chk("post-tmo pslverr", er, 1'b0);
        chk("post-tmo err pulses", to_n, 0);

        sq.push_back('{1000, 32'h0, 1'b0});
        @(negedge PCLK);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h50, 32'h0);
        @(negedge PCLK);
        drive(1, 1'b1, 1'b1, 1'b0, 32'h50, 32'h0);
        @(negedge PCLK);
        chk("pre-reset access", {S_PSEL, S_PENABLE, GRANT}, 4'b1110);
        #2 PRESET = 1'b1;
        #1;
        chk("async rst S_PSEL", S_PSEL, 1'b0);
        chk("async rst S_PENABLE", S_PENABLE, 1'b0);
        chk("async rst GRANT", GRANT, 2'b00);
        chk("async rst PREADY", {M0_PREADY, M1_PREADY}, 2'b00);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        sq.delete();
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        both_req("post-rst", 32'h0000_0033, 32'h0000_0044);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
